// File: rtl/axi2core_pkg.sv
// Shared types and constants for the AXI4 subordinate to core memory bridge.
package axi2core_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_e;

  // Number of address bits that select a byte within one data word.
  function automatic int unsigned offs_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle carrying the channels this bridge uses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic                      aw_valid, aw_ready;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;

  logic                      ar_valid, ar_ready;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;

  logic                      w_valid, w_ready, w_last;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;

  logic                      r_valid, r_ready, r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic [AXI_USER_WIDTH-1:0] r_user;

  logic                      b_valid, b_ready;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;

  modport Master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input r_valid, r_id, r_data, r_resp, r_last, r_user, output r_ready,
    input b_valid, b_id, b_resp, b_user, output b_ready
  );

  modport Slave (
    input aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
    input ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
    input w_valid, w_data, w_strb, w_last, output w_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user, input r_ready,
    output b_valid, b_id, b_resp, b_user, input b_ready
  );
endinterface

// File: rtl/axi2core_addr_gen.sv
// Next beat address and unsupported-burst detection; purely combinational.
module axi2core_addr_gen
  import axi2core_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [ADDR_W-1:0]  next_addr_o,
  output logic               err_o
);
  localparam int unsigned OFFS_W = offs_w(DATA_W);

  always_comb begin
    err_o = (burst_i == BURST_WRAP) || (burst_i == 2'b11) || (32'(size_i) > OFFS_W);
    next_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + (ADDR_W'(1) << size_i);
  end
endmodule

// File: rtl/axi2core.sv
// AXI4 subordinate that replays bursts beat by beat on a req/gnt/rvalid memory port.
module axi2core
  import axi2core_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        data_req_o,
  input  logic                        data_gnt_i,
  input  logic                        data_rvalid_i,
  output logic [AXI_ADDR_WIDTH-1:0]   data_addr_o,
  output logic                        data_we_o,
  output logic [AXI_DATA_WIDTH/8-1:0] data_be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_wdata_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_rdata_i,
  AXI_BUS.Slave                       AXI_Slave
);
  localparam int unsigned BE_W = AXI_DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, ag_next;
  logic [LEN_W-1:0]          len_q, len_d, cnt_q, cnt_d;
  logic [SIZE_W-1:0]         size_q, size_d, ag_size;
  logic [BURST_W-1:0]        burst_q, burst_d, ag_burst;
  logic                      err_q, err_d, ag_err;
  logic                      last_wr_q, last_wr_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [BE_W-1:0]           wstrb_q, wstrb_d;
  logic                      sel_rd, sel_wr, beat_last;
  logic                      unused_c;

  assign unused_c  = AXI_Slave.w_last;
  // Round robin: on a tie the channel not served last wins.
  assign sel_rd    = AXI_Slave.ar_valid & (~AXI_Slave.aw_valid | last_wr_q);
  assign sel_wr    = AXI_Slave.aw_valid & ~sel_rd;
  assign beat_last = (cnt_q == len_q);

  // In IDLE the generator screens the incoming request, otherwise the latched one.
  always_comb begin
    ag_size  = size_q;
    ag_burst = burst_q;
    if (state_q == IDLE) begin
      ag_size  = sel_rd ? AXI_Slave.ar_size  : AXI_Slave.aw_size;
      ag_burst = sel_rd ? AXI_Slave.ar_burst : AXI_Slave.aw_burst;
    end
  end

  axi2core_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (ag_size),
    .burst_i     (ag_burst),
    .next_addr_o (ag_next),
    .err_o       (ag_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b1;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (sel_rd) begin
          id_d      = AXI_Slave.ar_id;
          addr_d    = AXI_Slave.ar_addr;
          len_d     = AXI_Slave.ar_len;
          size_d    = AXI_Slave.ar_size;
          burst_d   = AXI_Slave.ar_burst;
          cnt_d     = '0;
          err_d     = ag_err;
          rdata_d   = '0;
          last_wr_d = 1'b0;
          state_d   = ag_err ? RD_RESP : RD_REQ;
        end else if (sel_wr) begin
          id_d      = AXI_Slave.aw_id;
          addr_d    = AXI_Slave.aw_addr;
          len_d     = AXI_Slave.aw_len;
          size_d    = AXI_Slave.aw_size;
          burst_d   = AXI_Slave.aw_burst;
          cnt_d     = '0;
          err_d     = ag_err;
          last_wr_d = 1'b1;
          state_d   = WR_DATA;
        end
      end
      RD_REQ:  if (data_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (data_rvalid_i) begin
          rdata_d = data_rdata_i;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (AXI_Slave.r_ready) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            addr_d  = ag_next;
            state_d = err_q ? RD_RESP : RD_REQ;
          end
        end
      end
      WR_DATA: begin
        if (AXI_Slave.w_valid) begin
          if (!err_q) begin
            wdata_d = AXI_Slave.w_data;
            wstrb_d = AXI_Slave.w_strb;
            state_d = WR_REQ;
          end else if (beat_last) begin
            state_d = WR_RESP;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      WR_REQ:  if (data_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (data_rvalid_i) begin
          if (beat_last) begin
            state_d = WR_RESP;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            addr_d  = ag_next;
            state_d = WR_DATA;
          end
        end
      end
      WR_RESP: if (AXI_Slave.b_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_req_o         = 1'b0;
    data_we_o          = 1'b0;
    data_addr_o        = '0;
    data_be_o          = '0;
    data_wdata_o       = '0;
    AXI_Slave.ar_ready = 1'b0;
    AXI_Slave.aw_ready = 1'b0;
    AXI_Slave.w_ready  = 1'b0;
    AXI_Slave.r_valid  = 1'b0;
    AXI_Slave.r_last   = 1'b0;
    AXI_Slave.r_resp   = RESP_OKAY;
    AXI_Slave.r_data   = rdata_q;
    AXI_Slave.r_id     = id_q;
    AXI_Slave.r_user   = '0;
    AXI_Slave.b_valid  = 1'b0;
    AXI_Slave.b_resp   = RESP_OKAY;
    AXI_Slave.b_id     = id_q;
    AXI_Slave.b_user   = '0;
    unique case (state_q)
      IDLE: begin
        AXI_Slave.ar_ready = sel_rd & ~rst_i;
        AXI_Slave.aw_ready = sel_wr & ~rst_i;
      end
      RD_REQ: begin
        data_req_o  = 1'b1;
        data_addr_o = addr_q & ~AXI_ADDR_WIDTH'(BE_W - 1);
        data_be_o   = '1;
      end
      RD_RESP: begin
        AXI_Slave.r_valid = 1'b1;
        AXI_Slave.r_last  = beat_last;
        AXI_Slave.r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      WR_DATA: AXI_Slave.w_ready = 1'b1;
      WR_REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_addr_o  = addr_q & ~AXI_ADDR_WIDTH'(BE_W - 1);
        data_be_o    = wstrb_q;
        data_wdata_o = wdata_q;
      end
      WR_RESP: begin
        AXI_Slave.b_valid = 1'b1;
        AXI_Slave.b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/axi2core.md
# axi2core

AXI4 subordinate that accepts burst read and write transactions from an `AXI_BUS` manager and replays them beat by beat on the core-style data memory interface (req/gnt/rvalid). It is the counterpart of the core-side AXI manager bridge: it lets a system AXI interconnect reach a core-native memory or peripheral. The bridge keeps one AXI transaction and one memory request in flight at a time.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 32: AXI and memory address width.
- `AXI_DATA_WIDTH`, 32: data width; byte-enable width is `AXI_DATA_WIDTH/8`.
- `AXI_ID_WIDTH`, 16: AXI ID width.
- `AXI_USER_WIDTH`, 10: AXI user width; all user outputs are driven to 0.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic is clocked on `posedge clk_i`.
- `rst_i`  in  1  reset. Synchronous and active-high.
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory grant.
- `data_rvalid_i`  in  1  memory response valid. Asserted for writes too.
- `data_addr_o`  out  `AXI_ADDR_WIDTH`  word-aligned beat address.
- `data_we_o`  out  1  write enable.
- `data_be_o`  out  `AXI_DATA_WIDTH/8`  byte enables.
- `data_wdata_o`  out  `AXI_DATA_WIDTH`  write data.
- `data_rdata_i`  in  `AXI_DATA_WIDTH`  read data.
- `AXI_Slave`  `AXI_BUS.Slave`  AXI4 subordinate port.

## Operation
- FSM states:
  - `IDLE`: `arready` or `awready` is high for exactly the selected channel.
  - `RD_REQ`: `data_req_o` is high. Moves to `RD_WAIT` on `data_gnt_i`.
  - `RD_WAIT`: on `data_rvalid_i`, registers `data_rdata_i` into R and moves to `RD_RESP`.
  - `RD_RESP`: `rvalid` is high. On `rready`, goes to `RD_REQ` for the next beat, or to `IDLE` after the last beat.
  - `WR_DATA`: `wready` is high. A W handshake latches `wdata`/`wstrb` and moves to `WR_REQ`.
  - `WR_REQ`: `data_req_o` is high with `data_we_o`=1. Moves to `WR_WAIT` on `data_gnt_i`.
  - `WR_WAIT`: on `data_rvalid_i`, goes to `WR_DATA` for the next beat, or to `WR_RESP` after the last beat.
  - `WR_RESP`: `bvalid` is high. Moves to `IDLE` on `bready`.
- Arbitration in `IDLE`:
  - Only AR valid: serve read. Only AW valid: serve write.
  - Both valid: serve the channel not served last (round-robin). The flag resets to "write last", so the first tie goes to read.
- Latched per transaction: ID, address, len, size, burst. Beat counter runs 0..len.
- Beat address:
  - FIXED: constant.
  - INCR: previous address + 2^size, full-width add with no wrap.
  - `data_addr_o` is the beat address with the low log2(`AXI_DATA_WIDTH/8`) bits cleared.
- Byte enables: reads drive `data_be_o` all ones; writes drive `wstrb` unchanged.
- Error bursts (burst=WRAP, reserved burst, or size > log2(`AXI_DATA_WIDTH/8`)):
  - No memory request is issued.
  - Read: len+1 beats with `rresp`=SLVERR and `rdata`=0.
  - Write: all W beats are accepted and discarded, then `bresp`=SLVERR.
- Normal responses use OKAY. `rid`/`bid` return the latched ID.
- `rlast` is high on beat len only. A `wlast` that disagrees with the beat count is ignored: len alone defines the burst length.

## Timing
- Reset: every output is 0, including all ready/valid signals, `data_req_o` and data buses. The FSM enters `IDLE`.
- `rst_i` mid-transaction aborts it with no response. The manager must also be reset.
- AR handshake in cycle N: `data_req_o`=1 at N+1. With gnt at N+1 and rvalid at N+2, `rvalid`=1 at N+3.
- Minimum spacing between read beats is 3 cycles.
- Write beat: W handshake at N, req at N+1, rvalid at N+2 at the earliest.
- `bvalid` rises the cycle after the last write rvalid.
- `data_req_o` and its address, we, be and wdata stay stable until `data_gnt_i`.
- `rvalid`/`bvalid` and their payloads stay stable until the ready handshake.
- A gnt and rvalid arriving in the same cycle is illegal: the memory answers at least one cycle after gnt.

## Structure
- `axi2core_pkg`: resp codes (OKAY/EXOKAY/SLVERR/DECERR), burst encodings (FIXED/INCR/WRAP), the FSM state enum, and the byte-offset width function.
- Sub-module `axi2core_addr_gen`: takes current address, size and burst, and produces the next address plus the error flag. It is combinational.
- The top level holds the FSM, beat counter, latches and arbitration.

## Test plan
- Single read: AR addr=0x100, len=0, size=2, id=5; memory returns 0xDEADBEEF -> one R beat with rdata=0xDEADBEEF, rid=5, rresp=OKAY, rlast=1. Check N+3 latency.
- INCR write: AW addr=0x200, len=3, size=2; W data 0..3 with wstrb=0xF -> memory writes to 0x200, 0x204, 0x208, 0x20C in order; exactly one B with OKAY.
- FIXED read len=2 at 0x40 -> three memory reads, all at 0x40. Hold `rready` low for 5 cycles: rvalid and rdata stay stable.
- Simultaneous AR and AW after reset -> read is served first, then write. Next tie -> read first again, per alternation.
- WRAP burst len=1 write, then size=3 read -> no `data_req_o`; bresp=SLVERR; read returns 2 beats of SLVERR with rlast on the second.
- Assert `rst_i` while in `WR_WAIT` -> all outputs are 0 the next cycle. A fresh read afterwards completes normally.
